// File: rtl/sprite_anim_draw.sv
// Animated, mirrorable, scalable sprite drawer. Position, mirror and scale are shadowed on frame_tick. Output follows pixel input by 2 clk edges.
// Free-running pipeline with no backpressure. Bitmap RAM reads return old data on a same-address write.
module sprite_anim_draw #(
   parameter int          SPR_W       = 32,
   parameter int          SPR_H       = 32,
   parameter int          FRAMES      = 4,
   parameter int          COORD_W     = 11,
   parameter logic [11:0] TRANSPARENT = 12'hFFF,
   parameter int          ADDR_W      = $clog2(FRAMES*SPR_W*SPR_H),
   parameter int          FIDX_W      = (FRAMES > 1) ? $clog2(FRAMES) : 1
) (
   input  logic               clk,
   input  logic               reset,
   input  logic [COORD_W-1:0] pxl_x,
   input  logic [COORD_W-1:0] pxl_y,
   input  logic               frame_tick,
   input  logic [COORD_W-1:0] top_left_x,
   input  logic [COORD_W-1:0] top_left_y,
   input  logic               mirror_x,
   input  logic               mirror_y,
   input  logic [1:0]         scale,
   input  logic               anim_en,
   input  logic [7:0]         anim_period,
   input  logic               wr_en,
   input  logic [ADDR_W-1:0]  wr_addr,
   input  logic [11:0]        wr_data,
   output logic [3:0]         red_level,
   output logic [3:0]         green_level,
   output logic [3:0]         blue_level,
   output logic               drawing,
   output logic [FIDX_W-1:0]  frame_idx
);

   localparam int PIX   = SPR_W * SPR_H;
   localparam int DEPTH = FRAMES * PIX;
   localparam int CX_W  = $clog2(SPR_W);
   localparam int RY_W  = $clog2(SPR_H);
   localparam int EXT_W = COORD_W + 3;

   logic [COORD_W-1:0] tlx_q, tlx_d, tly_q, tly_d;
   logic               mirx_q, mirx_d, miry_q, miry_d;
   logic [1:0]         scale_q, scale_d;
   logic [7:0]         cnt_q, cnt_d;
   logic [FIDX_W-1:0]  fidx_q, fidx_d;
   logic               hit_s1_q, drawing_q, drawing_d;
   logic [11:0]        data_s1_q, rgb_q, rgb_d;
   logic [11:0]        mem [DEPTH];

   always_comb begin
      tlx_d   = tlx_q;
      tly_d   = tly_q;
      mirx_d  = mirx_q;
      miry_d  = miry_q;
      scale_d = scale_q;
      cnt_d   = cnt_q;
      fidx_d  = fidx_q;
      if (frame_tick) begin
         tlx_d   = top_left_x;
         tly_d   = top_left_y;
         mirx_d  = mirror_x;
         miry_d  = mirror_y;
         scale_d = (scale == 2'd3) ? 2'd2 : scale;
         if (!anim_en) begin
            cnt_d = '0;
         end else if (cnt_q == anim_period) begin
            cnt_d  = '0;
            fidx_d = (fidx_q == FIDX_W'(FRAMES-1)) ? '0 : fidx_q + 1'b1;
         end else begin
            cnt_d = cnt_q + 8'd1;
         end
      end
   end

   // Extended width keeps tl+extent from wrapping near the screen edge.
   logic [EXT_W-1:0]  px_e, py_e, tx_e, ty_e, dx, dy, ew, eh;
   logic              hit;
   logic [CX_W-1:0]   col;
   logic [RY_W-1:0]   row;
   logic [ADDR_W-1:0] rd_addr;

   always_comb begin
      px_e = EXT_W'(pxl_x);
      py_e = EXT_W'(pxl_y);
      tx_e = EXT_W'(tlx_q);
      ty_e = EXT_W'(tly_q);
      dx   = px_e - tx_e;
      dy   = py_e - ty_e;
      ew   = EXT_W'(SPR_W) << scale_q;
      eh   = EXT_W'(SPR_H) << scale_q;
      hit  = (px_e >= tx_e) && (dx < ew) && (py_e >= ty_e) && (dy < eh);
      // Power-of-2 sizes make SIZE-1-idx a bitwise inversion.
      col  = CX_W'(dx >> scale_q) ^ {CX_W{mirx_q}};
      row  = RY_W'(dy >> scale_q) ^ {RY_W{miry_q}};
      rd_addr = ADDR_W'(fidx_q) * ADDR_W'(PIX) + ADDR_W'({row, col});
   end

   always_ff @(posedge clk) begin
      if (wr_en) begin
         mem[wr_addr] <= wr_data;
      end
      data_s1_q <= mem[rd_addr];
   end

   always_comb begin
      drawing_d = hit_s1_q && (data_s1_q != TRANSPARENT);
      rgb_d     = drawing_d ? data_s1_q : rgb_q;
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         tlx_q     <= '0;
         tly_q     <= '0;
         mirx_q    <= 1'b0;
         miry_q    <= 1'b0;
         scale_q   <= '0;
         cnt_q     <= '0;
         fidx_q    <= '0;
         hit_s1_q  <= 1'b0;
         drawing_q <= 1'b0;
         rgb_q     <= 12'hFFF;
      end else begin
         tlx_q     <= tlx_d;
         tly_q     <= tly_d;
         mirx_q    <= mirx_d;
         miry_q    <= miry_d;
         scale_q   <= scale_d;
         cnt_q     <= cnt_d;
         fidx_q    <= fidx_d;
         hit_s1_q  <= hit;
         drawing_q <= drawing_d;
         rgb_q     <= rgb_d;
      end
   end

   assign drawing     = drawing_q;
   assign red_level   = rgb_q[11:8];
   assign green_level = rgb_q[7:4];
   assign blue_level  = rgb_q[3:0];
   assign frame_idx   = fidx_q;

endmodule
